// File: rtl/cgra_sram_arb_pkg.sv
// Shared types and constants for the CGRA SRAM bank arbiter.
// Holds the retention FSM state type, the SRAM word/byte-enable widths,
// and a small modular-index helper used by the round-robin search.
package cgra_sram_arb_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      DRAIN  = 2'd1,
      RET    = 2'd2,
      WAKE   = 2'd3
   } arb_state_e;

   localparam int unsigned SramBeWidth   = 4;
   localparam int unsigned SramDataWidth = 32;

   // (base + offset) mod n, used to walk requesters starting at the pointer.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/cgra_rr_arbiter.sv
// Combinational round-robin picker: the winner is the first asserted
// request at or after the priority pointer, searching upward and wrapping.
module cgra_rr_arbiter
   import cgra_sram_arb_pkg::*;
#(
   parameter  int unsigned NumReq   = 4,
   localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0]   i_req,
   input  logic [IdxWidth-1:0] i_ptr,
   output logic [NumReq-1:0]   o_gnt,
   output logic [IdxWidth-1:0] o_idx,
   output logic                o_valid
);

   // Scan requesters from the pointer; the first hit wins and stops the scan.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (!o_valid && i_req[wrap_idx(32'(i_ptr), i, NumReq)]) begin
            o_gnt[wrap_idx(32'(i_ptr), i, NumReq)] = 1'b1;
            o_idx   = IdxWidth'(wrap_idx(32'(i_ptr), i, NumReq));
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cgra_sram_arbiter.sv
// Shares one single-port SRAM bank among NumReq requesters (CGRA columns
// plus host port) with a same-cycle round-robin grant, routes the 1-cycle
// response back to the granted requester, and sequences retention mode.
// Optional feature macro: CGRA_SRAM_ARB_HOST_PRIO_EN gives requester 0
// (host bus) absolute priority; round-robin then covers 1..NumReq-1 only.
//
// Handshake: a requester holds req_i[i] and its fields stable until it sees
// gnt_o[i]=1 in the same cycle; the access is then taken. Exactly one cycle
// later rvalid_o[i]=1 for both reads and writes, with rdata_o valid for reads.
module cgra_sram_arbiter
   import cgra_sram_arb_pkg::*;
#(
   parameter  int unsigned NumReq    = 4,
   parameter  int unsigned NumWords  = 1024,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [NumReq-1:0]                       req_i,
   input  logic [NumReq-1:0]                       we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]        addr_i,
   input  logic [NumReq-1:0][SramDataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][SramBeWidth-1:0]      be_i,
   output logic [NumReq-1:0]                       gnt_o,
   output logic [NumReq-1:0]                       rvalid_o,
   output logic [SramDataWidth-1:0]                rdata_o,
   output logic                                    mem_req_o,
   output logic                                    mem_we_o,
   output logic [AddrWidth-1:0]                    mem_addr_o,
   output logic [SramDataWidth-1:0]                mem_wdata_o,
   output logic [SramBeWidth-1:0]                  mem_be_o,
   output logic                                    mem_set_retentive_o,
   input  logic [SramDataWidth-1:0]                mem_rdata_i,
   input  logic                                    ret_req_i,
   output logic                                    ret_ack_o,
   output arb_state_e                              dbg_state_o
);

   localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

   arb_state_e          r_state;
   logic [IdxWidth-1:0] r_rr_ptr;
   logic                r_pend_valid;
   logic [IdxWidth-1:0] r_pend_idx;
   logic                r_ret_ack;

   logic [NumReq-1:0]   w_arb_req;
   logic [NumReq-1:0]   w_arb_gnt;
   logic [IdxWidth-1:0] w_arb_idx;
   logic                w_arb_valid;
   logic [NumReq-1:0]   w_sel_gnt;
   logic [IdxWidth-1:0] w_sel_idx;
   logic                w_sel_valid;
   logic                w_ptr_move;
   logic                w_do_gnt;
   logic [IdxWidth-1:0] w_next_ptr;

   // Requests seen by the round-robin picker (host masked out when it has priority).
   always_comb begin
      w_arb_req = req_i;
`ifdef CGRA_SRAM_ARB_HOST_PRIO_EN
      w_arb_req[0] = 1'b0;
`endif
   end

   cgra_rr_arbiter #(
      .NumReq (NumReq)
   ) u_rr_arbiter (
      .i_req   (w_arb_req),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // Final winner selection; a host win overrides round-robin and leaves the pointer alone.
   always_comb begin
      w_sel_gnt   = w_arb_gnt;
      w_sel_idx   = w_arb_idx;
      w_sel_valid = w_arb_valid;
      w_ptr_move  = 1'b1;
`ifdef CGRA_SRAM_ARB_HOST_PRIO_EN
      if (req_i[0]) begin
         w_sel_gnt   = NumReq'(1);
         w_sel_idx   = '0;
         w_sel_valid = 1'b1;
         w_ptr_move  = 1'b0;
      end
`endif
   end

   // Grants only in ACTIVE, never while retention is requested, never in reset.
   assign w_do_gnt   = rst_ni && (r_state == ACTIVE) && !ret_req_i && w_sel_valid;
   assign w_next_ptr = (w_sel_idx == IdxWidth'(NumReq - 1)) ? '0 : w_sel_idx + 1'b1;

   assign gnt_o       = w_do_gnt ? w_sel_gnt : '0;
   assign mem_req_o   = w_do_gnt;
   assign mem_we_o    = w_do_gnt & we_i[w_sel_idx];
   assign mem_addr_o  = w_do_gnt ? addr_i[w_sel_idx]  : '0;
   assign mem_wdata_o = w_do_gnt ? wdata_i[w_sel_idx] : '0;
   assign mem_be_o    = w_do_gnt ? be_i[w_sel_idx]    : '0;

   assign ret_ack_o           = r_ret_ack;
   assign mem_set_retentive_o = r_ret_ack;
   assign dbg_state_o         = r_state;

   // Response routing; a response pending when reset arrives is dropped at once.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (rst_ni && r_pend_valid) begin
         rvalid_o[r_pend_idx] = 1'b1;
         rdata_o              = mem_rdata_i;
      end
   end

   // Retention FSM, round-robin pointer and pending-response register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= ACTIVE;
         r_rr_ptr     <= '0;
         r_pend_valid <= 1'b0;
         r_pend_idx   <= '0;
         r_ret_ack    <= 1'b0;
      end else begin
         r_pend_valid <= w_do_gnt;
         if (w_do_gnt) begin
            r_pend_idx <= w_sel_idx;
         end
         if (w_do_gnt && w_ptr_move) begin
            r_rr_ptr <= w_next_ptr;
         end
         case (r_state)
            ACTIVE: begin
               if (ret_req_i) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               r_state   <= RET;
               r_ret_ack <= 1'b1;
            end
            RET: begin
               if (!ret_req_i) begin
                  r_state   <= WAKE;
                  r_ret_ack <= 1'b0;
               end
            end
            WAKE: begin
               r_state <= ACTIVE;
            end
            default: begin
               r_state   <= ACTIVE;
               r_ret_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule
